prio_encoder_rr: RTL
====================

// Module: prio_encoder_rr
// PURPOSE
//   Parametrised N-to-log2(N) priority encoder with a registered output stage.
//   Output stage uses a valid/ready handshake and flags multi-hot or all-zero request vectors.
//   Priority is fixed (highest index wins) or round-robin, selected by the RR parameter.
//   Sits between request sources (interrupt lines, arbiter requesters) and a downstream consumer.
// PARAMETERS
//   N      8   number of request inputs, >= 2
//   IDX_W  3   index width; must equal $clog2(N)
//   RR     0   0 = fixed priority (highest index wins); 1 = round-robin priority
// PORTS
//   clk        in   1        rising-edge clock
//   rst        in   1        asynchronous reset, active-high
//   req        in   N        request vector, sampled on accept
//   in_valid   in   1        req is valid this cycle
//   in_ready   out  1        block can accept req this cycle
//   out_idx    out  IDX_W    encoded index of the winning request
//   out_multi  out  1        more than one bit was set in the accepted req
//   out_cnt    out  IDX_W+1  popcount of the accepted req
//   out_valid  out  1        out_idx/out_multi/out_cnt are valid
//   out_ready  in   1        consumer takes the output this cycle
//   empty_err  out  1        one-cycle pulse: accepted req was all-zero
// BEHAVIOUR
// - Reset (async, any time incl. mid-transfer):
//   - out_idx=0, out_multi=0, out_cnt=0, out_valid=0, empty_err=0, RR pointer ptr=0.
//   - Pending output is discarded.
// - in_ready = !out_valid || out_ready (combinational; no bubble on back-to-back transfers).
// - Accept = in_valid && in_ready.
//   - Result is registered; out_valid rises the cycle after accept (latency 1).
// - Accept with req != 0:
//   - out_valid<=1; out_idx<=winner; out_multi<=(popcount>1); out_cnt<=popcount.
// - Accept with req == 0:
//   - out_valid<=0; empty_err<=1 for exactly one cycle.
//   - out_idx/out_multi/out_cnt hold their previous values.
// - No accept:
//   - If out_valid && out_ready, then out_valid<=0.
//   - Otherwise all outputs hold (stable while stalled).
//   - empty_err<=0.
// - Winner, RR=0: highest set index of req.
// - Winner, RR=1: first set bit scanning upward from ptr: ptr, ptr+1, ... N-1, 0, ... ptr-1.
// - ptr update (RR=1 only):
//   - On accept with req != 0: ptr <= (winner == N-1) ? 0 : winner+1 (wrap).
//   - Zero-vector accepts leave ptr unchanged.
// - RR=0: ptr is unused and held at 0.
// - Simultaneous out_valid && out_ready && in_valid:
//   - New result loads the next cycle.
//   - out_valid stays 1; no idle cycle in between.
// - out_cnt is full-width IDX_W+1 so that req = all-ones gives out_cnt = N (no overflow).
// - Outputs are never X. A multi-hot req is resolved by priority and flagged via out_multi.
// TESTING (N=8, IDX_W=3)
// - Fixed priority, RR=0, out_ready=1:
//   - req=8'b0010_0101 -> next cycle out_valid=1, out_idx=5, out_multi=1, out_cnt=3.
// - Round-robin wrap, RR=1, out_ready=1, req=8'h81 three times back-to-back:
//   - out_idx = 0, 7, 0.
//   - ptr = 1, 0, 1.
//   - out_valid stays high throughout.
// - Backpressure:
//   - First, result idx=2 is pending with out_ready=0 for 4 cycles -> in_ready=0.
//   - New req=8'h80 during those cycles is not accepted; out_idx stays 2.
//   - Then out_ready=1 -> 8'h80 is accepted; next cycle out_idx=7.
// - Zero vector: req=8'h00 accepted:
//   - empty_err=1 for one cycle; out_valid=0; ptr and out_idx unchanged.
// - Full vector: req=8'hFF:
//   - out_cnt=8, out_multi=1.
//   - out_idx=7 with RR=0; out_idx=ptr with RR=1.
// - Reset mid-operation:
//   - rst asserted asynchronously while out_valid=1 and ptr=5.
//   - Outputs go to 0 immediately, without waiting for a clock edge; ptr=0.
//   - First accept after release with req=8'h21, RR=1 -> out_idx=0.

Source files
------------

// File: rtl/prio_encoder_rr.sv
// prio_encoder_rr: N-to-log2(N) priority encoder with a registered
// valid/ready output stage. The winner is picked either by fixed priority
// (highest index wins) or by round-robin priority starting at an internal
// pointer. The output stage also reports the popcount of the accepted
// vector, flags multi-hot vectors, and pulses empty_err for all-zero vectors.
module prio_encoder_rr #(
    parameter int N     = 8,
    parameter int IDX_W = 3,
    parameter int RR    = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     req,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_multi,
    output logic [IDX_W:0]   out_cnt,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             empty_err
);

    // Number of set bits in a request vector; full width so all-ones fits.
    function automatic logic [IDX_W:0] popcount(input logic [N-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < N; i++) begin
            c = c + {{IDX_W{1'b0}}, v[i]};
        end
        return c;
    endfunction

    logic             accept_s;
    logic             nonzero_s;
    logic [IDX_W:0]   cnt_s;
    logic [IDX_W-1:0] fixed_idx_s;
    logic [IDX_W-1:0] rr_idx_s;
    logic [IDX_W-1:0] winner_s;
    logic [IDX_W-1:0] ptr_next_s;
    logic [IDX_W-1:0] ptr_r;

    // A new vector can enter whenever the output slot is empty or being drained.
    assign in_ready  = !out_valid || out_ready;
    assign accept_s  = in_valid && in_ready;
    assign nonzero_s = |req;
    assign cnt_s     = popcount(req);

    // Fixed priority: scanning upward, the last set bit seen is the highest index.
    always_comb begin
        fixed_idx_s = '0;
        for (int i = 0; i < N; i++) begin
            if (req[i]) begin
                fixed_idx_s = IDX_W'(i);
            end else begin
                fixed_idx_s = fixed_idx_s;
            end
        end
    end

    // Round-robin priority: first set bit scanning upward from ptr, wrapping at N-1.
    always_comb begin : rr_scan
        logic             found;
        logic [IDX_W-1:0] pos;
        int               j;
        rr_idx_s = '0;
        found    = 1'b0;
        pos      = '0;
        j        = 0;
        for (int k = 0; k < N; k++) begin
            j = int'(ptr_r) + k;
            if (j >= N) begin
                j = j - N;
            end else begin
                j = j;
            end
            pos = IDX_W'(j);
            if (!found && req[pos]) begin
                found    = 1'b1;
                rr_idx_s = pos;
            end else begin
                found = found;
            end
        end
    end

    // Select the priority scheme and compute where the round-robin pointer moves next.
    always_comb begin
        winner_s   = fixed_idx_s;
        ptr_next_s = ptr_r;
        if (RR != 0) begin
            winner_s = rr_idx_s;
            if (int'(rr_idx_s) == N - 1) begin
                ptr_next_s = '0;
            end else begin
                ptr_next_s = rr_idx_s + IDX_W'(1);
            end
        end else begin
            winner_s   = fixed_idx_s;
            ptr_next_s = '0;
        end
    end

    // Output register stage and round-robin pointer; reset discards any pending result.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_idx   <= '0;
            out_multi <= 1'b0;
            out_cnt   <= '0;
            out_valid <= 1'b0;
            empty_err <= 1'b0;
            ptr_r     <= '0;
        end else if (accept_s) begin
            if (nonzero_s) begin
                out_valid <= 1'b1;
                out_idx   <= winner_s;
                out_multi <= (cnt_s > (IDX_W+1)'(1));
                out_cnt   <= cnt_s;
                empty_err <= 1'b0;
                ptr_r     <= ptr_next_s;
            end else begin
                // All-zero vector: nothing to report, result fields keep old values.
                out_valid <= 1'b0;
                empty_err <= 1'b1;
                ptr_r     <= ptr_r;
            end
        end else begin
            if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end else begin
                out_valid <= out_valid;
            end
            empty_err <= 1'b0;
            ptr_r     <= ptr_r;
        end
    end

endmodule
